// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed/unsigned multiply and divide into Hi/Lo.
// The unit resolves one result bit per clock under a Start/Busy/Done handshake.
// Optional feature macro: MULTDIV_DIV_EN.
//   When it is defined, the restoring divider is built and DIV/DIVU compute
//   the quotient and remainder.
//   When it is undefined, the divider is removed. DIV/DIVU then finish
//   through the divide-by-zero path.
// Op encoding: bit 1 selects divide, and bit 0 selects unsigned.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  // Operation attributes latched at Start; the operand ports are free after that.
  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic sign_a;
    logic sign_b;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q, req_in;
  logic [WIDTH-1:0] acc_hi, acc_lo;   // {acc_hi, acc_lo} is the 2*WIDTH working register
  logic [WIDTH-1:0] opnd;             // |A| for multiply, |B| for divide
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             zero_path;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Input decode: the operand magnitudes, and whether the request skips straight to FIX.
  always_comb begin
    req_in.is_div    = Op[1];
    req_in.is_signed = ~Op[0];
    req_in.sign_a    = ~Op[0] & A[WIDTH-1];
    req_in.sign_b    = ~Op[0] & B[WIDTH-1];
    a_mag            = req_in.sign_a ? -A : A;
    b_mag            = req_in.sign_b ? -B : B;
    accept           = Start & ((state == S_IDLE) | (state == S_DONE));
`ifdef MULTDIV_DIV_EN
    zero_path        = Op[1] & (B == '0);
`else
    zero_path        = Op[1];
`endif
  end

  // FSM state register; Reset wins over everything, including a same-cycle Start.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state, with Busy and Done decoded from the state.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = zero_path ? S_FIX : S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        Busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = accept ? (zero_path ? S_FIX : S_RUN) : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration.
  // Multiply: shift-add, so the multiplier bits leave acc_lo as product bits enter.
  // Divide: restoring shift-subtract, so quotient bits fill acc_lo from the right.
  always_comb begin
    logic [WIDTH:0] add;
    add     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    step_hi = add[WIDTH:1];
    step_lo = {add[0], acc_lo[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
    if (req_q.is_div) begin
      logic [WIDTH:0] shifted, diff;
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  // Sign correction of the raw magnitude result.
  // The quotient is negated when the operand signs differ.
  // The remainder takes the sign of the dividend.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod = {acc_hi, acc_lo};
    if (req_q.sign_a ^ req_q.sign_b) prod = -prod;
    {res_hi, res_lo} = prod;
`ifdef MULTDIV_DIV_EN
    if (req_q.is_div) begin
      res_lo = (req_q.sign_a ^ req_q.sign_b) ? -acc_lo : acc_lo;
      res_hi = req_q.sign_a ? -acc_hi : acc_hi;
    end
`endif
  end

  // Datapath registers.
  // Operands load on an accepted Start, one iteration runs per RUN cycle,
  // and Hi/Lo commit only when leaving FIX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      cnt     <= '0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            req_q   <= req_in;
            acc_hi  <= '0;
            acc_lo  <= Op[1] ? a_mag : b_mag;
            opnd    <= Op[1] ? b_mag : a_mag;
            cnt     <= CW'(WIDTH);
            DivZero <= zero_path;
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
        end
        S_FIX: begin
          if (!DivZero) begin
            Hi <= res_hi;
            Lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32).
// The stimulus side predicts each result with plain integer arithmetic and queues it.
// The monitor side compares every Done pulse, the Busy window and the Hi/Lo hold behaviour.
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [1:0]   Op;
  logic [W-1:0] A, B;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] hi, lo;
    bit           dz;
  } exp_t;

  exp_t         sbq[$];
  int           n_checks = 0, n_errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;      // predicted Hi/Lo after the last issued op
  logic [W-1:0] mon_hi = '0, mon_lo = '0;  // Hi/Lo that should be visible right now
  int           busy_from = 1, busy_until = 0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference model built from the arithmetic rules, using 64-bit integer math.
  function automatic exp_t predict(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t                 e;
    logic signed [2*W-1:0] sa, sb, sp;
    logic [2*W-1:0]        ua, ub, up;
    sa = $signed(a); sb = $signed(b);
    ua = a;          ub = b;
    e.cyc = 0; e.dz = 1'b0; e.hi = m_hi; e.lo = m_lo;
    case (op)
      2'd0: begin sp = sa * sb; {e.hi, e.lo} = sp; end
      2'd1: begin up = ua * ub; {e.hi, e.lo} = up; end
      default: begin
        if (!DIV_EN || b == '0) e.dz = 1'b1;
        else if (op == 2'd2) begin
          sp = sa / sb; e.lo = sp[W-1:0];
          sp = sa % sb; e.hi = sp[W-1:0];
        end else begin
          up = ua / ub; e.lo = up[W-1:0];
          up = ua % ub; e.hi = up[W-1:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: checks the Busy window, pops an entry on each expected Done, and checks Hi/Lo hold.
  always @(negedge Clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", W'(Busy), W'(cyc >= busy_from && cyc <= busy_until));
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        chk("done", W'(Done), W'(1));
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("divzero", W'(DivZero), W'(e.dz));
        mon_hi = e.hi;
        mon_lo = e.lo;
      end else begin
        chk("no_done", W'(Done), W'(0));
      end
      chk("hold_hi", Hi, mon_hi);
      chk("hold_lo", Lo, mon_lo);
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Issue one op as soon as the unit is idle.
  // Entered and left at posedge+1; the task returns in cycle 1 of the op.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    exp_t e;
    int   t = 0;
    repeat (gap) step();
    while (Busy && t < 200) begin step(); t++; end
    if (Busy) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle @cyc %0d: got busy=1 want busy=0 within 200 cycles", cyc);
      return;
    end
    Op = op; A = a; B = b; Start = 1'b1;
    e = predict(op, a, b);
    e.cyc = cyc + (e.dz ? 2 : W + 2);
    sbq.push_back(e);
    busy_from  = cyc + 1;
    busy_until = e.cyc - 1;
    m_hi = e.hi; m_lo = e.lo;
    step();
    Start = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, W'(Busy), W'(0));
    chk({tag, "_done"}, W'(Done), W'(0));
    chk({tag, "_divzero"}, W'(DivZero), W'(0));
    chk({tag, "_hi"}, Hi, '0);
    chk({tag, "_lo"}, Lo, '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check_cleared("reset");
    mon_en = 1'b1;

    // Directed cases, including the back-to-back starts issued in the Done cycle.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'd7, 32'd2, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'd7, 32'd2, 0);
    run_op(2'd2, 32'd5, 32'd0, 0);
    run_op(2'd0, 32'd12, 32'hFFFF_FFFE, 0);

    // A Start pulse in cycle 5 of a run, with different operands, must be ignored.
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    repeat (4) step();
    Start = 1'b1; Op = 2'd0; A = 32'd3; B = 32'd3;
    step();
    Start = 1'b0;

    // A Reset in cycle 10 of a run discards that run.
    run_op(2'd0, 32'h0000_FFFF, 32'h0001_0001, 0);
    repeat (9) step();
    Reset = 1'b1;
    sbq.delete();
    busy_until = cyc;
    step();
    Reset = 1'b0;
    m_hi = '0; m_lo = '0; mon_hi = '0; mon_lo = '0;
    check_cleared("midrun_reset");

    // A result, then a DIVU by zero so that DivZero is set going into the next reset.
    run_op(2'd3, 32'd100, 32'd7, 1);
    run_op(2'd3, 32'd9, 32'd0, 0);
    repeat (3) step();

    // Reset and Start asserted in the same cycle: Reset wins.
    Reset = 1'b1; Start = 1'b1; Op = 2'd0; A = 32'd3; B = 32'd5;
    step();
    Reset = 1'b0; Start = 1'b0;
    m_hi = '0; m_lo = '0; mon_hi = '0; mon_lo = '0;
    check_cleared("reset_start");

    // Random ops mixing corner values and zero divisors.
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 2));

    t = 0;
    while (sbq.size() > 0 && t < 200) begin step(); t++; end
    if (sbq.size() > 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: got %0d pending results want 0", sbq.size());
    end
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
